wb_excp_stage: RTL



---
 rtl/wb_excp_stage_pkg.sv | 50 +++++
 rtl/wb_excp_stage_excp_arbiter.sv | 50 +++++
 rtl/wb_excp_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_excp_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_excp_stage_pkg
// Description : Shared definitions for the writeback / exception stage:
//               exception cause bit indices, ecode/subcode values, the
//               post-flush FSM encoding and the latched MEM->WB bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_excp_stage_pkg;

  // Bit positions inside the ms_exc cause vector
  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_ALE  = 4;

  // Exception codes as seen by the csr block
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_NONE = 9'd0;

  // Post-flush FSM: KILL lasts exactly one cycle after a flush
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_KILL   = 1'b1
  } ws_state_e;

  // Latched copy of the MEM->WB bundle
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        ertn;
    logic [4:0]  exc;
  } ws_bundle_t;

endpackage
`default_nettype wire

// File: rtl/wb_excp_stage_excp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : excp_arbiter
// Description : Combinational exception cause priority encoder.
//               Priority: INT > ADEF > INE > SYS > BRK > ALE.
// Ports       : valid_i     - WB stage holds an instruction
//               has_int_i   - interrupt pending
//               exc_i[4:0]  - synchronous cause vector
//               ex_any_o    - any cause is taken
//               ecode_o     - selected exception code
//               esubcode_o  - selected exception subcode
// Revision    : 1.0 - initial release
// ============================================================================
module excp_arbiter
  import wb_excp_stage_pkg::*;
(
  input  logic       valid_i,
  input  logic       has_int_i,
  input  logic [4:0] exc_i,
  output logic       ex_any_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o
);

  always_comb begin
    ex_any_o   = 1'b0;
    ecode_o    = ECODE_INT;
    esubcode_o = ESUBCODE_NONE;
    // A bubble never takes a cause, including a pending interrupt
    if (valid_i) begin
      ex_any_o = has_int_i | (|exc_i);
      if (has_int_i) begin
        ecode_o = ECODE_INT;
      end else if (exc_i[EXC_ADEF]) begin
        ecode_o    = ECODE_ADEF;
        esubcode_o = ESUBCODE_ADEF;
      end else if (exc_i[EXC_INE]) begin
        ecode_o = ECODE_INE;
      end else if (exc_i[EXC_SYS]) begin
        ecode_o = ECODE_SYS;
      end else if (exc_i[EXC_BRK]) begin
        ecode_o = ECODE_BRK;
      end else if (exc_i[EXC_ALE]) begin
        ecode_o = ECODE_ALE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_excp_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_excp_stage
// Description : Writeback stage. Latches the MEM->WB bundle, arbitrates
//               exception causes plus the sampled interrupt, commits regfile
//               and CSR writes of non-excepting instructions, and raises a
//               one-cycle upstream flush with redirect target on exception
//               or ertn commit. The cycle after a flush is a KILL cycle in
//               which any arriving instruction is discarded.
// Ports       : clk/reset           - clock, synchronous active-high reset
//               ms_* / ms_to_ws_valid, ws_allowin - MEM->WB handshake+bundle
//               has_int, excp_pc, ertn_pc         - from csr
//               wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
//               csr_we, csr_wnum, csr_wmask, csr_wdata - to csr
//               rf_we, rf_waddr, rf_wdata         - to regfile
//               ws_flush, flush_target            - pipeline flush/redirect
// Config      : WB_DEBUG_TRACE_EN adds debug_wb_* golden-trace outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_excp_stage
  import wb_excp_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  // MEM->WB
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wdata,
  input  logic        ms_ertn,
  input  logic [4:0]  ms_exc,
  // CSR side
  input  logic        has_int,
  input  logic [31:0] excp_pc,
  input  logic [31:0] ertn_pc,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic [3:0]  csr_we,
  output logic [13:0] csr_wnum,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  // Regfile and flush
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_flush,
  output logic [31:0] flush_target
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  ws_state_e  state_q;
  logic       ws_valid_q;
  logic       ws_valid_d;
  ws_bundle_t bundle_q;
  ws_bundle_t bundle_d;

  logic       ws_ready_go;
  logic       ex_any;
  logic       commit_ok;

  assign ws_ready_go = 1'b1;
  // In KILL ws_valid_q is always 0 (the flush cycle drops its offer), so
  // this also keeps allowin high through KILL.
  assign ws_allowin  = !ws_valid_q || ws_ready_go;

  // Offers coinciding with a flush, or arriving during KILL, are dropped
  assign ws_valid_d = ms_to_ws_valid && ws_allowin && !ws_flush
                      && (state_q == ST_NORMAL);

  always_comb begin
    bundle_d.pc        = ms_pc;
    bundle_d.rf_we     = ms_rf_we;
    bundle_d.rf_waddr  = ms_rf_waddr;
    bundle_d.rf_wdata  = ms_rf_wdata;
    bundle_d.csr_we    = ms_csr_we;
    bundle_d.csr_num   = ms_csr_num;
    bundle_d.csr_wmask = ms_csr_wmask;
    bundle_d.csr_wdata = ms_csr_wdata;
    bundle_d.ertn      = ms_ertn;
    bundle_d.exc       = ms_exc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      ws_valid_q <= 1'b0;
      bundle_q   <= '0;
    end else begin
      case (state_q)
        ST_NORMAL: if (ws_flush) state_q <= ST_KILL;
        ST_KILL:   state_q <= ST_NORMAL;
        default:   state_q <= ST_NORMAL;
      endcase
      ws_valid_q <= ws_valid_d;
      if (ws_valid_d) begin
        bundle_q <= bundle_d;
      end
    end
  end

  excp_arbiter u_excp_arbiter (
    .valid_i    (ws_valid_q),
    .has_int_i  (has_int),
    .exc_i      (bundle_q.exc),
    .ex_any_o   (ex_any),
    .ecode_o    (wb_ecode),
    .esubcode_o (wb_esubcode)
  );

  assign commit_ok    = ws_valid_q && !ex_any;

  assign wb_ex        = ws_valid_q && ex_any;
  assign ertn_flush   = commit_ok && bundle_q.ertn;
  assign ws_flush     = wb_ex || ertn_flush;
  assign flush_target = wb_ex ? excp_pc : ertn_pc;
  assign wb_pc        = ws_valid_q ? bundle_q.pc : RESET_PC;

  assign rf_we        = commit_ok && bundle_q.rf_we;
  assign rf_waddr     = bundle_q.rf_waddr;
  assign rf_wdata     = bundle_q.rf_wdata;

  assign csr_we       = {4{commit_ok && bundle_q.csr_we}};
  assign csr_wnum     = bundle_q.csr_num;
  assign csr_wmask    = bundle_q.csr_wmask;
  assign csr_wdata    = bundle_q.csr_wdata;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
`default_nettype wire
